cam_fb_writer: RTL and testbench

//   Bridges the camera capture stage and the frame-buffer RAM. Pairs the capture

---
 rtl/cam_fb_writer.sv | 114 +++++++++++
 tb/tb_cam_fb_writer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cam_fb_writer.sv
// Camera-to-frame-buffer bridge: pairs RGB565 bytes into pixels, packs them to RGB332
// and writes them at sequential RAM addresses, aligned to frame boundaries.
module cam_fb_writer #(
  parameter int AW      = 19,
  parameter int DW      = 8,
  parameter int MAX_PIX = 19200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          pixel_valid,
  input  logic [7:0]    pixel_data,
  input  logic          frame_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_we,
  output logic          mem_en,
  output logic          frame_ready,
  output logic [7:0]    frame_count,
  output logic          overflow,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} state_t;

  localparam logic [AW-1:0] PIX_LIMIT = AW'(MAX_PIX);

  state_t        state, state_nxt;
  logic [AW-1:0] addr;
  logic          phase;
  logic [7:0]    hi_p0;

  function automatic logic [DW-1:0] pack_rgb332(input logic [7:0] hi, input logic [7:0] lo);
    return DW'({hi[7:5], hi[2:0], lo[4:3]});
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A capture request with enable low while syncing is dropped before a frame can start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = SYNC;
      SYNC: begin
        if (!enable)         state_nxt = IDLE;
        else if (frame_done) state_nxt = CAPTURE;
      end
      CAPTURE: if (frame_done && !enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy   = (state == CAPTURE);
  assign mem_en = mem_we;

  // Stage p0: high byte of the pixel in flight
  always_ff @(posedge clk) begin
    if (state == CAPTURE && pixel_valid && !phase) hi_p0 <= pixel_data;
  end

  // Stage p1: registered RAM write and frame bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      addr        <= '0;
      phase       <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      frame_ready <= 1'b0;
      frame_count <= '0;
      overflow    <= 1'b0;
    end else begin
      mem_we      <= 1'b0;
      frame_ready <= 1'b0;
      case (state)
        SYNC: begin
          addr  <= '0;
          phase <= 1'b0;
        end
        CAPTURE: begin
          if (pixel_valid) begin
            if (!phase) begin
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (addr < PIX_LIMIT) begin
                mem_we   <= 1'b1;
                mem_addr <= addr;
                mem_data <= pack_rgb332(hi_p0, pixel_data);
                addr     <= addr + AW'(1);
              end else begin
                overflow <= 1'b1;
              end
            end
          end
          // Closing the frame overrides the byte bookkeeping above; a write
          // issued on the same edge still uses the pre-close address.
          if (frame_done) begin
            frame_ready <= 1'b1;
            frame_count <= frame_count + 8'd1;
            addr        <= '0;
            phase       <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_fb_writer.sv
// Directed bench for cam_fb_writer: sync, packing, full frame, overrun, odd bytes, reset.
module tb_cam_fb_writer;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int MAX_PIX = 19200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          pixel_valid = 1'b0;
  logic [7:0]    pixel_data = 8'h00;
  logic          frame_done = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we, mem_en, frame_ready, overflow, busy;
  logic [7:0]    frame_count;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int addr_err = 0;
  int exp_addr = 0;
  int w0;

  cam_fb_writer #(.AW(AW), .DW(DW), .MAX_PIX(MAX_PIX)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pixel_valid(pixel_valid),
    .pixel_data(pixel_data), .frame_done(frame_done), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_we(mem_we), .mem_en(mem_en),
    .frame_ready(frame_ready), .frame_count(frame_count),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Write monitor: every write must land at the next expected address, inside the frame.
  always @(negedge clk) begin
    if (mem_we) begin
      if (int'(mem_addr) != exp_addr || int'(mem_addr) >= MAX_PIX || !mem_en) addr_err++;
      exp_addr++;
      wr_cnt++;
    end
    if (frame_ready || rst) exp_addr = 0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    pixel_valid = 1'b1;
    pixel_data  = b;
    tick();
    pixel_valid = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] hi, input logic [7:0] lo);
    send_byte(hi);
    send_byte(lo);
  endtask

  task automatic pulse_fd();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic send_frame(input int npix);
    for (int i = 0; i < npix; i++) begin
      logic [31:0] v;
      v = i;
      send_pix(v[7:0], ~v[7:0]);
    end
  endtask

  initial begin
    // Reset state and pre-sync bytes
    tick(); tick();
    chk("reset_outputs", {mem_we, mem_en, frame_ready, overflow, busy, frame_count, mem_addr, mem_data}, '0);
    rst = 1'b0;
    enable = 1'b1;
    tick();
    w0 = wr_cnt;
    send_pix(8'hF8, 8'h00);
    tick();
    chk("presync_no_write", wr_cnt - w0, 0);
    chk("presync_busy", busy, 0);
    pulse_fd();
    chk("sync_busy", busy, 1);
    chk("sync_no_count", frame_count, 0);

    // Packing of primaries
    send_pix(8'hF8, 8'h00);
    chk("red_pix", {mem_we, mem_addr, mem_data}, {1'b1, 19'd0, 8'hE0});
    send_pix(8'h07, 8'hE0);
    chk("green_pix", {mem_we, mem_addr, mem_data}, {1'b1, 19'd1, 8'h1C});
    send_pix(8'h00, 8'h1F);
    chk("blue_pix", {mem_we, mem_addr, mem_data}, {1'b1, 19'd2, 8'h03});
    tick();
    chk("we_single_cycle", mem_we, 0);
    pulse_fd();
    chk("short_frame_ready", {frame_ready, frame_count}, {1'b1, 8'd1});
    tick();
    chk("frame_ready_pulse", frame_ready, 0);

    // Full frame from a fresh reset
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    pulse_fd();
    w0 = wr_cnt;
    send_frame(MAX_PIX);
    pulse_fd();
    chk("full_writes", wr_cnt - w0, MAX_PIX);
    chk("full_ready_cnt_ovf", {frame_ready, frame_count, overflow}, {1'b1, 8'd1, 1'b0});
    chk("full_last_write", {mem_addr, mem_data}, {19'd19199, 8'hFC});

    // Overrun by one pixel
    w0 = wr_cnt;
    send_frame(MAX_PIX);
    chk("ovf_not_yet", overflow, 0);
    send_pix(8'h12, 8'h34);
    chk("ovf_set", {overflow, mem_we}, {1'b1, 1'b0});
    chk("ovf_writes", wr_cnt - w0, MAX_PIX);
    send_pix(8'h56, 8'h78);
    chk("ovf_sticky_addr_hold", {overflow, mem_we, mem_addr}, {1'b1, 1'b0, 19'd19199});
    pulse_fd();
    chk("ovf_cleared", {overflow, frame_ready, frame_count}, {1'b0, 1'b1, 8'd2});

    // Odd byte count and coincident strobes
    w0 = wr_cnt;
    send_byte(8'hAA);
    pulse_fd();
    tick();
    chk("odd_dropped", wr_cnt - w0, 0);
    chk("odd_count", frame_count, 3);
    send_pix(8'hF8, 8'h00);
    chk("phase_realigned", {mem_we, mem_addr, mem_data}, {1'b1, 19'd0, 8'hE0});
    send_byte(8'h07);
    pixel_valid = 1'b1; pixel_data = 8'hE0; frame_done = 1'b1;
    tick();
    pixel_valid = 1'b0; frame_done = 1'b0;
    chk("coinc_write", {mem_we, mem_addr, mem_data, frame_ready, frame_count},
        {1'b1, 19'd1, 8'h1C, 1'b1, 8'd4});
    pixel_valid = 1'b1; pixel_data = 8'hF8; frame_done = 1'b1;
    tick();
    pixel_valid = 1'b0; frame_done = 1'b0;
    chk("coinc_hi_dropped", {mem_we, frame_ready, frame_count}, {1'b0, 1'b1, 8'd5});
    send_pix(8'h00, 8'h1F);
    chk("after_coinc_pix", {mem_we, mem_addr, mem_data}, {1'b1, 19'd0, 8'h03});

    // Reset mid-frame at address 500
    pulse_fd();
    send_frame(500);
    chk("mid_addr", mem_addr, 499);
    rst = 1'b1; tick();
    chk("mid_reset", {mem_we, mem_en, frame_ready, overflow, busy, frame_count, mem_addr, mem_data}, '0);
    tick();
    rst = 1'b0;

    // Enable dropped mid-frame finishes the frame
    tick();
    pulse_fd();
    send_frame(3);
    enable = 1'b0;
    send_frame(2);
    chk("disable_still_busy", {busy, mem_we, mem_addr}, {1'b1, 1'b1, 19'd4});
    pulse_fd();
    chk("disable_close", {frame_ready, frame_count, busy}, {1'b1, 8'd1, 1'b0});
    send_pix(8'hF8, 8'h00);
    chk("idle_no_write", {busy, mem_we}, {1'b0, 1'b0});
    chk("monitor_addr_seq", addr_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
